// File: rtl/gpio_pad_bank.sv
// GPIO pad bank: tristate/open-drain pad drivers plus a synchronised, debounced input path
// with edge detection and sticky interrupt pending bits.
module gpio_pad_bank #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] oe_i,
  input  logic [WIDTH-1:0] out_i,
  input  logic [WIDTH-1:0] od_i,
  input  logic [WIDTH-1:0] rise_en_i,
  input  logic [WIDTH-1:0] fall_en_i,
  input  logic [WIDTH-1:0] irq_clr_i,
  inout  wire  [WIDTH-1:0] pad_io,
  output logic [WIDTH-1:0] in_o,
  output logic [WIDTH-1:0] pending_o,
  output logic             irq_o
);

  // Open-drain pins only ever pull low; a '1' releases the pad.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign pad_io[i] = (oe_i[i] && !(od_i[i] && out_i[i])) ? (out_i[i] & ~od_i[i]) : 1'bz;
  end

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sync_last;
  logic [WIDTH-1:0]                  in_q, in_d;
  logic [WIDTH-1:0]                  pending_q, pending_d;
  logic [WIDTH-1:0]                  rise, fall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_io};
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign in_d = sync_last;
  end else begin : g_debounce
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;

    // Any cycle agreeing with the accepted level restarts the count, rejecting short glitches.
    always_comb begin
      cnt_d = cnt_q;
      in_d  = in_q;
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (sync_last[i] == in_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntMax) begin
          in_d[i]  = sync_last[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  // Edges come from next-state so pending sets on the same edge in_o updates.
  assign rise = in_d & ~in_q;
  assign fall = ~in_d & in_q;

  // Set has priority over a coincident clear.
  assign pending_d = (pending_q & ~irq_clr_i) | (rise & rise_en_i) | (fall & fall_en_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_q      <= '0;
      pending_q <= '0;
    end else begin
      in_q      <= in_d;
      pending_q <= pending_d;
    end
  end

  assign in_o      = in_q;
  assign pending_o = pending_q;
  assign irq_o     = |pending_q;

endmodule
